mem_stage_dreq: RTL and testbench

//  Memory-stage consumer of the EX/MEM latch outputs. Turns latched dmemREN/dmemWEN plus the
//  ALU address and store data into a held request/dhit handshake to the dcache. Stalls the

---
 rtl/mem_stage_dreq_if.sv | 15 +
 rtl/mem_stage_dreq.sv | 93 +++++++++
 tb/tb_mem_stage_dreq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_stage_dreq_if.sv
// mem_stage_dreq_if: EX/MEM request inputs, dcache handshake and MEM/WB outputs of the memory stage
interface mem_stage_dreq_if #(parameter int DATA_W = 32);
    logic              flush, ren, wen, dhit;
    logic [DATA_W-1:0] addr, wdat, dmemload;
    logic              dmemREN, dmemWEN, stall, done, misalign, timeout;
    logic [DATA_W-1:0] dmemaddr, dmemstore, dload;
    modport master (
        input  flush, ren, wen, addr, wdat, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, stall, done, dload, misalign, timeout
    );
    modport slave (
        output flush, ren, wen, addr, wdat, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall, done, dload, misalign, timeout
    );
endinterface

// File: rtl/mem_stage_dreq.sv
// mem_stage_dreq: holds a dcache request for the MEM-stage access, stalls upstream until dhit/timeout
module mem_stage_dreq #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_stage_dreq_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdat_q, wdat_d, dload_q, dload_d;
    logic              wr_q, wr_d, kill_q, kill_d, mis_q, mis_d, to_q, to_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req, aligned;
    assign req     = bus.ren | bus.wen;
    assign aligned = bus.addr[1:0] == 2'b00;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        dload_d = dload_q;
        wr_d    = wr_q;
        kill_d  = kill_q;
        mis_d   = mis_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req && !bus.flush) begin
                if (aligned) begin
                    addr_d  = bus.addr;
                    wdat_d  = bus.wdat;
                    wr_d    = bus.wen;
                    state_d = ACCESS;
                end else begin
                    mis_d   = 1'b1;
                    state_d = DONE;
                end
            end
            ACCESS: begin
                cnt_d  = cnt_q + 8'd1;
                // a flush coinciding with dhit still squashes the result
                kill_d = kill_q | bus.flush;
                if (bus.dhit) begin
                    dload_d = (!wr_q && !kill_d) ? bus.dmemload : dload_q;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = 8'd0;
                kill_d  = 1'b0;
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            dload_q <= '0;
            wr_q    <= 1'b0;
            kill_q  <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            dload_q <= dload_d;
            wr_q    <= wr_d;
            kill_q  <= kill_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.stall     = (state_q == IDLE && req && !bus.flush && aligned) || state_q == ACCESS;
    assign bus.dmemREN   = state_q == ACCESS && !wr_q;
    assign bus.dmemWEN   = state_q == ACCESS && wr_q;
    assign bus.dmemaddr  = addr_q;
    assign bus.dmemstore = wdat_q;
    assign bus.done      = state_q == DONE && !kill_q && !mis_q;
    assign bus.misalign  = state_q == DONE && mis_q;
    assign bus.dload     = dload_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_mem_stage_dreq.sv
// tb_mem_stage_dreq: directed + random memory-stage accesses, scoreboard of done/misalign pulses
module tb_mem_stage_dreq;
    localparam int TO = 4;
    typedef struct packed {
        logic        mis;
        logic [31:0] dload;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0, fails = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] dload_m = '0;
    logic to_m = 1'b0;
    mem_stage_dreq_if #(.DATA_W(32)) bus ();
    mem_stage_dreq #(.DATA_W(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic chkb(input string n, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && (bus.done || bus.misalign)) begin
            if (q.size() == 0) chkb("unexpected_pulse", 1'b1, 1'b0);
            else begin
                e = q.pop_front();
                chkb("misalign_pulse", bus.misalign, e.mis);
                chkb("done_pulse", bus.done, !e.mis);
                chk("dload", bus.dload, e.dload);
            end
        end
    end
    task automatic op(input bit wr, input bit rd_too, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ld, input int dly, input int fl);
        bit hit, killed;
        int last;
        hit    = dly < TO;
        last   = hit ? dly : TO - 1;
        killed = fl >= 0 && fl <= last;
        @(negedge clk);
        bus.ren = !wr || rd_too; bus.wen = wr; bus.addr = a; bus.wdat = d;
        bus.flush = 1'b0; bus.dhit = 1'($urandom); bus.dmemload = $urandom;
        if (a[1:0] != 2'b00) q.push_back('{1'b1, dload_m});
        else begin
            if (!hit) to_m = 1'b1;
            if (hit && !wr && !killed) dload_m = ld;
            if (!killed) q.push_back('{1'b0, dload_m});
        end
        #1 chkb("stall_issue", bus.stall, a[1:0] == 2'b00);
        @(negedge clk);
        bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = $urandom; bus.wdat = $urandom; bus.dhit = 1'b0;
        if (a[1:0] != 2'b00) begin
            #1 chkb("mis_stall", bus.stall, 1'b0);
            chkb("mis_noreq", bus.dmemREN | bus.dmemWEN, 1'b0);
            return;
        end
        for (int k = 0; k <= last; k++) begin
            if (k > 0) @(negedge clk);
            bus.flush = k == fl; bus.dhit = k == dly; bus.dmemload = (k == dly) ? ld : $urandom;
            bus.addr = $urandom;
            #1 chkb("acc_ren", bus.dmemREN, !wr);
            chkb("acc_wen", bus.dmemWEN, wr);
            chkb("acc_stall", bus.stall, 1'b1);
            chk("acc_addr", bus.dmemaddr, a);
            if (wr) chk("acc_store", bus.dmemstore, d);
        end
        @(negedge clk);
        bus.flush = 1'b0; bus.dhit = 1'($urandom);
        #1 chkb("done_stall", bus.stall, 1'b0);
        chkb("done_noreq", bus.dmemREN | bus.dmemWEN, 1'b0);
        chkb("timeout", bus.timeout, to_m);
    endtask
    initial begin
        bus.ren = 0; bus.wen = 0; bus.flush = 0; bus.dhit = 0;
        bus.addr = '0; bus.wdat = '0; bus.dmemload = '0;
        repeat (2) @(negedge clk);
        chkb("rst_stall", bus.stall, 1'b0);
        chkb("rst_req", bus.dmemREN | bus.dmemWEN, 1'b0);
        chkb("rst_pulses", bus.done | bus.misalign | bus.timeout, 1'b0);
        chk("rst_dload", bus.dload, 32'h0);
        chk("rst_addr", bus.dmemaddr, 32'h0);
        rst = 1'b0;
        op(0, 0, 32'h40, 32'h0, 32'hDEADBEEF, 2, -1);
        op(1, 0, 32'h80, 32'h1234, 32'h0, 0, -1);
        op(0, 0, 32'h42, 32'h0, 32'h0, 0, -1);
        op(0, 0, 32'h44, 32'h0, 32'h55555555, 2, 0);
        op(1, 1, 32'h88, 32'hCAFE, 32'h0, 1, -1);
        @(negedge clk);
        bus.ren = 1'b1; bus.flush = 1'b1; bus.addr = 32'h90;
        #1 chkb("flush_idle_stall", bus.stall, 1'b0);
        @(negedge clk);
        bus.ren = 1'b0; bus.flush = 1'b0;
        #1 chkb("flush_idle_noreq", bus.dmemREN, 1'b0);
        op(0, 0, 32'h48, 32'h0, 32'h0, 9, -1);
        op(0, 0, 32'h4C, 32'h0, 32'h600DF00D, 1, -1);
        @(negedge clk);
        bus.ren = 1'b1; bus.addr = 32'h100;
        @(negedge clk);
        bus.ren = 1'b0;
        #1 chkb("pre_rst_ren", bus.dmemREN, 1'b1);
        rst = 1'b1;
        #1 chkb("async_rst_ren", bus.dmemREN, 1'b0);
        chkb("async_rst_stall", bus.stall, 1'b0);
        chkb("async_rst_timeout", bus.timeout, 1'b0);
        q.delete(); dload_m = '0; to_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        op(0, 0, 32'h104, 32'h0, 32'h12345678, 1, -1);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            op(1'($urandom), 1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 5)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
